button_debouncer_bank: RTL and testbench
========================================

# button_debouncer_bank

Parametrised multi-channel push-button conditioner: per channel, a two-flop synchroniser, a glitch-rejecting debounce counter, one-cycle press/release pulses and an optional hold/auto-repeat generator. It replaces the single-channel debouncer on the FPGA board front end. It feeds clean button events to the emulator/debugger control logic (run/step/reset-target/menu buttons) without extra edge detectors downstream.

## Interface
- `N_CH`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 65536: consecutive stable synchronised samples required to accept a level change; ≥2.
- `ACTIVE_LOW`, 1: 1 means a pin at 0 is "pressed"; 0 means a pin at 1 is "pressed". Applies to all channels.
- `REPEAT_EN`, 1: 1 enables the hold/auto-repeat logic; 0 ties `held` and `repeat` to 0.
- `HOLD_CYCLES`, 25000000: cycles from the press pulse to the first repeat pulse; ≥2.
- `REPEAT_CYCLES`, 5000000: cycles between subsequent repeat pulses; ≥2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pb`  in  N_CH  raw asynchronous button pins.
- `state`  out  N_CH  debounced level; 1 means pressed.
- `press`  out  N_CH  one-cycle pulse on an accepted released→pressed change.
- `release`  out  N_CH  one-cycle pulse on an accepted pressed→released change.
- `held`  out  N_CH  level; high from the first repeat pulse until release.
- `repeat`  out  N_CH  one-cycle auto-repeat pulse while held.

## Operation
- Sync: `pb` is XOR'd with `ACTIVE_LOW` to get the normalised pressed level, then passed through two flops (`s0`, `s1`). On reset, `s0` and `s1` take 0 (released), so no spurious press follows reset.
- Debounce counter:
  - Width is clog2(DEBOUNCE_CYCLES).
  - Cleared whenever `s1 == state`.
  - Otherwise it increments.
  - When `s1 != state` and the counter equals DEBOUNCE_CYCLES−1, `state` toggles and the counter clears. There is no wrap-around.
- Pulses: `press` and `release` are registered and asserted in exactly the first cycle that `state` shows the new value.
- Per-channel FSM (REPEAT_EN=1), states IDLE, PRESSED, HELD:
  - IDLE → PRESSED on accepted press. The hold counter is loaded with 0.
  - PRESSED: the hold counter increments each cycle. On reaching HOLD_CYCLES−1 it goes → HELD, `repeat` pulses, `held` rises, and the counter reloads with 0.
  - HELD: the counter increments. On reaching REPEAT_CYCLES−1, `repeat` pulses and the counter reloads with 0.
  - PRESSED or HELD → IDLE on accepted release. `held` falls in the same cycle `release` is asserted.
- Simultaneous events: if a release is accepted in the same cycle a repeat would fire, release wins. No `repeat` is emitted, the FSM goes to IDLE, and the counter clears.
- Channels are fully independent; events on different channels in the same cycle are all reported.
- Reset mid-operation, on the edge after `reset` is sampled high:
  - All outputs go to 0.
  - The FSM goes to IDLE.
  - All counters and sync flops clear.
  - A button still held after reset is re-accepted as a fresh press after the full debounce latency.

## Timing
- Reset value of every output: `state`=0, `press`=0, `release`=0, `held`=0, `repeat`=0.
- Acceptance latency: call the rising edge that first samples the new pin level edge 1. `state`, `press` and `release` update on edge DEBOUNCE_CYCLES+2.
- Glitch rejection: a pin excursion lasting ≤DEBOUNCE_CYCLES−1 cycles never changes `state`. One lasting DEBOUNCE_CYCLES cycles is accepted.
- First `repeat`: HOLD_CYCLES cycles after the `press` cycle. Subsequent `repeat` pulses are REPEAT_CYCLES cycles apart.
- No combinational path from `pb` to any output.

## Structure
- Package `button_pkg`:
  - enum `btn_state_t` {IDLE, PRESSED, HELD}.
  - width helper functions for the counters.
- Sub-module `button_channel`: one channel (sync, debounce counter, FSM, pulse registers). It is instantiated N_CH times in a generate loop. The top level only parameterises the channels and concatenates their outputs.

## Test plan
All scenarios use N_CH=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_LOW=1.
- Reset release with `pb`=2'b11 -> all outputs 0 for 20 cycles. With `pb`=2'b00 held through reset -> `press` asserted on edge 6 after reset deasserts.
- `pb[0]` driven to 0 for 3 cycles then back to 1 -> `state[0]` stays 0, with no `press` or `release`. Driven low for 4 cycles -> `press[0]` on edge 6, then `release[0]` on edge 6 after the pin returns high.
- `pb[0]` held low for 40 cycles:
  - `press` at cycle P.
  - `repeat` at P+10, P+15, P+20, …
  - `held` high from P+10 until `release`.
- Release timed so its acceptance coincides with a scheduled `repeat` -> `release` pulses, `repeat` stays 0, `held` falls the same cycle.
- Both channels pressed on the same edge, with 1-cycle bounces on `pb[1]` only -> `press[0]` on edge 6. `press[1]` is delayed until `pb[1]` has been stable for 4 cycles. The channels do not interact.
- `reset` asserted for one cycle while in HELD -> every output is 0 on the next edge. No `release` pulse is generated.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type and counter width helpers for the debouncer bank.
package button_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} btn_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int hold_w(input int h, input int r);
    return cnt_w((h > r) ? h : r);
  endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: one button: sync, debounce, press/release pulses, hold/auto-repeat FSM.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int ACTIVE_LOW      = 1,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic pb,
  output logic state,
  output logic press,
  output logic release_evt,
  output logic held,
  output logic repeat_evt
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = hold_w(HOLD_CYCLES, REPEAT_CYCLES);
  logic s0, s1, accept, held_n, rpt_n;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt, hcnt_n;
  btn_state_t fsm, fsm_n;
  assign accept = (s1 != state) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      dcnt        <= '0;
      state       <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      fsm         <= IDLE;
      hcnt        <= '0;
      held        <= 1'b0;
      repeat_evt  <= 1'b0;
    end else begin
      s0          <= pb ^ (ACTIVE_LOW != 0);
      s1          <= s0;
      dcnt        <= (s1 == state || accept) ? '0 : dcnt + 1'b1;
      state       <= state ^ accept;
      press       <= accept & ~state;
      release_evt <= accept & state;
      fsm         <= fsm_n;
      hcnt        <= hcnt_n;
      held        <= held_n;
      repeat_evt  <= rpt_n;
    end
  end
  // An accepted release pre-empts any repeat due in the same cycle.
  always_comb begin
    fsm_n  = fsm;
    hcnt_n = hcnt + 1'b1;
    held_n = held;
    rpt_n  = 1'b0;
    if (!REPEAT_EN) begin
      fsm_n  = IDLE;
      hcnt_n = '0;
      held_n = 1'b0;
    end else if (accept && state) begin
      fsm_n  = IDLE;
      hcnt_n = '0;
      held_n = 1'b0;
    end else if (accept) begin
      fsm_n  = PRESSED;
      hcnt_n = '0;
    end else begin
      unique case (fsm)
        IDLE: hcnt_n = '0;
        PRESSED: if (hcnt == HW'(HOLD_CYCLES - 1)) begin
          fsm_n  = HELD;
          hcnt_n = '0;
          held_n = 1'b1;
          rpt_n  = 1'b1;
        end
        HELD: if (hcnt == HW'(REPEAT_CYCLES - 1)) begin
          hcnt_n = '0;
          rpt_n  = 1'b1;
        end
        default: fsm_n = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/button_debouncer_bank.sv
// button_debouncer_bank: N_CH independent debounced button channels with press/release/repeat events.
module button_debouncer_bank
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int ACTIVE_LOW      = 1,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] state,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_evt,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] repeat_evt
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_EN      (REPEAT_EN),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .pb         (pb[i]),
      .state      (state[i]),
      .press      (press[i]),
      .release_evt(release_evt[i]),
      .held       (held[i]),
      .repeat_evt (repeat_evt[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer_bank.sv
// tb_button_debouncer_bank: scoreboard bench; events are queued at stimulus time and checked each cycle.
module tb_button_debouncer_bank;
  localparam int K_PRESS = 0, K_REL = 1, K_RPT = 2;
  typedef struct {int cyc; int ch; int kind;} ev_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] pb = 2'b11;
  logic [1:0] state, press, release_evt, held, repeat_evt;
  logic [1:0] es = 2'b00, eh = 2'b00;
  ev_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;

  button_debouncer_bank #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(1'b1),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .pb(pb), .state(state), .press(press),
    .release_evt(release_evt), .held(held), .repeat_evt(repeat_evt)
  );

  always #5 clk = ~clk;

  task automatic expect_ev(input int c, input int ch, input int k);
    q.push_back('{c, ch, k});
  endtask

  // Advance one edge, then drain this edge's expected events and compare all outputs.
  task automatic cycle();
    logic [1:0] ep, er, ert;
    @(negedge clk);
    cyc++;
    ep = '0; er = '0; ert = '0;
    if (reset) begin es = '0; eh = '0; end
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc == cyc) begin
        if (q[i].kind == K_PRESS) ep[q[i].ch] = 1'b1;
        else if (q[i].kind == K_REL) er[q[i].ch] = 1'b1;
        else ert[q[i].ch] = 1'b1;
        q.delete(i);
      end
    es = (es | ep) & ~er;
    eh = (eh & ~er) | ert;
    n_chk += 5;
    if (press !== ep) begin n_fail++; $display("FAIL press @%0d got %b want %b", cyc, press, ep); end
    if (release_evt !== er) begin n_fail++; $display("FAIL release @%0d got %b want %b", cyc, release_evt, er); end
    if (repeat_evt !== ert) begin n_fail++; $display("FAIL repeat @%0d got %b want %b", cyc, repeat_evt, ert); end
    if (state !== es) begin n_fail++; $display("FAIL state @%0d got %b want %b", cyc, state, es); end
    if (held !== eh) begin n_fail++; $display("FAIL held @%0d got %b want %b", cyc, held, eh); end
  endtask

  task automatic test_reset();
    repeat (3) cycle();
    reset = 1'b0;
    repeat (20) cycle();
    n_chk++;
    if ({state, press, release_evt, held, repeat_evt} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 0", {state, press, release_evt, held, repeat_evt});
    end
  endtask

  task automatic test_reset_held();
    int t;
    reset = 1'b1;
    pb = 2'b00;
    repeat (3) cycle();
    reset = 1'b0;
    t = cyc;
    expect_ev(t + 6, 0, K_PRESS);
    expect_ev(t + 6, 1, K_PRESS);
    repeat (6) cycle();
    n_chk++;
    if (press !== 2'b11) begin n_fail++; $display("FAIL reset_held_press got %b want 11", press); end
    pb = 2'b11;
    expect_ev(cyc + 6, 0, K_REL);
    expect_ev(cyc + 6, 1, K_REL);
    repeat (8) cycle();
  endtask

  task automatic test_glitch();
    pb[0] = 1'b0;
    repeat (3) cycle();
    pb[0] = 1'b1;
    repeat (10) cycle();
    n_chk++;
    if (state[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_state got %b want 0", state[0]); end
    pb[0] = 1'b0;
    expect_ev(cyc + 6, 0, K_PRESS);
    repeat (4) cycle();
    pb[0] = 1'b1;
    expect_ev(cyc + 6, 0, K_REL);
    repeat (10) cycle();
  endtask

  task automatic test_repeat();
    int p;
    pb[0] = 1'b0;
    p = cyc + 6;
    expect_ev(p, 0, K_PRESS);
    for (int k = 10; k < 40; k += 5) expect_ev(p + k, 0, K_RPT);
    repeat (40) cycle();
    pb[0] = 1'b1;
    expect_ev(p + 40, 0, K_REL);
    repeat (10) cycle();
  endtask

  task automatic test_coincide();
    int p;
    pb[0] = 1'b0;
    p = cyc + 6;
    expect_ev(p, 0, K_PRESS);
    expect_ev(p + 10, 0, K_RPT);
    repeat (15) cycle();
    pb[0] = 1'b1;
    expect_ev(p + 15, 0, K_REL);
    while (cyc < p + 15) cycle();
    n_chk++;
    if ({release_evt[0], repeat_evt[0], held[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL coincide got rel/rpt/held %b want 100", {release_evt[0], repeat_evt[0], held[0]});
    end
    repeat (8) cycle();
  endtask

  task automatic test_bounce();
    int t;
    t = cyc;
    pb = 2'b00;
    expect_ev(t + 6, 0, K_PRESS);
    expect_ev(t + 10, 1, K_PRESS);
    expect_ev(t + 16, 0, K_RPT);
    for (int i = 0; i < 4; i++) begin
      cycle();
      pb[1] = ~pb[1];
    end
    repeat (8) cycle();
    pb = 2'b11;
    expect_ev(t + 18, 0, K_REL);
    expect_ev(t + 18, 1, K_REL);
    repeat (10) cycle();
  endtask

  task automatic test_reset_in_held();
    int p;
    pb[0] = 1'b0;
    p = cyc + 6;
    expect_ev(p, 0, K_PRESS);
    expect_ev(p + 10, 0, K_RPT);
    while (cyc < p + 12) cycle();
    reset = 1'b1;
    cycle();
    n_chk++;
    if ({state[0], held[0], release_evt[0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_in_held got state/held/rel %b want 000", {state[0], held[0], release_evt[0]});
    end
    reset = 1'b0;
    expect_ev(cyc + 6, 0, K_PRESS);
    repeat (7) cycle();
    pb[0] = 1'b1;
    expect_ev(cyc + 6, 0, K_REL);
    repeat (10) cycle();
    n_chk++;
    if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_held();
    test_glitch();
    test_repeat();
    test_coincide();
    test_bounce();
    test_reset_in_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
